// File: rtl/weight_pkg.sv
// Shared constants and types for the weight loader: FP32 layout, FSM states, default weight.
package weight_pkg;

    localparam int unsigned FP32_W      = 32;
    localparam int unsigned FP32_EXP_W  = 8;
    localparam int unsigned FP32_MANT_W = 23;

    localparam logic [FP32_W-1:0] W_DEFAULT_VAL = 32'h3F20_0000;

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_MANT_W-1:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fp32_nonfinite_detect.sv
// Combinational FP32 non-finite test: exponent field all ones (Inf or NaN).
module fp32_nonfinite_detect
    import weight_pkg::*;
(
    input  logic [FP32_EXP_W-1:0] exp,
    output logic                  nonfinite_c
);

    assign nonfinite_c = &exp;

endmodule

// File: rtl/weight_loader.sv
// Sequences upstream FP32 words onto a shared bus with one-hot load strobes.
// Optional non-finite substitution enabled by WEIGHT_LOADER_NAN_CHECK_EN.
module weight_loader
    import weight_pkg::*;
#(
    parameter int unsigned        NUM_W     = 4,
    parameter logic [FP32_W-1:0]  W_DEFAULT = W_DEFAULT_VAL
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       init_default,
    input  logic                       in_valid,
    input  logic [FP32_W-1:0]          in_data,
    output logic                       in_ready,
    output logic [FP32_W-1:0]          w_bus,
    output logic [NUM_W-1:0]           load,
    output logic                       set_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_W)-1:0]   idx,
    output logic                       err
);

    localparam int unsigned IDX_W = $clog2(NUM_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_W - 1);

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx_d;
    logic [NUM_W-1:0]   load_d;
    logic [FP32_W-1:0]  w_bus_d;
    logic               err_d;
    logic               set_d, done_d, busy_d, in_ready_d;
    logic               xfer_c;
    logic               nonfinite_c;
    logic [FP32_W-1:0]  word_sel_c;

`ifdef WEIGHT_LOADER_NAN_CHECK_EN
    fp32_t in_word;
    assign in_word = fp32_t'(in_data);

    fp32_nonfinite_detect u_nonfinite (
        .exp         (in_word.exp),
        .nonfinite_c (nonfinite_c)
    );
`else
    assign nonfinite_c = 1'b0;
`endif

    assign word_sel_c = nonfinite_c ? W_DEFAULT : in_data;
    assign xfer_c     = (state == LOAD) && in_valid && in_ready;

    // Next-state and next-output logic; status outputs follow the next state.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        load_d  = '0;
        w_bus_d = w_bus;
        err_d   = err;

        unique case (state)
            IDLE: begin
                if (init_default) begin
                    state_d = INIT;
                end else if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            INIT: state_d = IDLE;
            LOAD: begin
                if (xfer_c) begin
                    w_bus_d = word_sel_c;
                    load_d  = NUM_W'(1) << idx;
                    if (nonfinite_c) err_d = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        set_d      = (state_d == INIT);
        done_d     = (state_d == DONE);
        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            load     <= '0;
            w_bus    <= '0;
            set_out  <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            load     <= load_d;
            w_bus    <= w_bus_d;
            set_out  <= set_d;
            done     <= done_d;
            busy     <= busy_d;
            in_ready <= in_ready_d;
            err      <= err_d;
        end
    end

endmodule
